// File: rtl/spr16x4_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spr16x4_ctrl_if
// Description : Bundle of the command channel, response channel and RAM pins
//               of spr16x4_ctrl.
//               slave  = controller side
//               master = fabric / RAM side
//               Command channel : cmd_valid, cmd_ready, cmd_op, cmd_addr,
//                                 cmd_data
//               Response channel: rsp_valid, rsp_ready, rsp_data, rsp_addr
//               RAM pins        : mem_ad, mem_di, mem_wre, mem_do
// Revision    : 1.0  initial release
// ============================================================================
interface spr16x4_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_data;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] rsp_addr;

  logic [3:0] mem_ad;
  logic [3:0] mem_di;
  logic       mem_wre;
  logic [3:0] mem_do;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_do,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, mem_ad, mem_di, mem_wre
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_do,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, mem_ad, mem_di, mem_wre
  );
endinterface
`default_nettype wire

// File: rtl/spr16x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spr16x4_ctrl
// Description : Command-driven initiator for a 16x4 single-port LUT-RAM
//               (synchronous write, asynchronous read). Executes read, write,
//               add (read-modify-write) and clear-all commands and returns
//               one response per command.
// Ports       : ck_i    - clock, all state on rising edge
//               rstn_i  - asynchronous active-low reset
//               bus     - command/response channels and RAM pins (slave)
//               busy_o  - controller not in IDLE
// Parameters  : CLR_ON_RESET - sweep all words to 0 after reset release
//               SAT          - add saturates at 4'hF instead of wrapping
// Revision    : 1.0  initial release
// ============================================================================
module spr16x4_ctrl #(
  parameter bit CLR_ON_RESET = 1'b1,
  parameter bit SAT          = 1'b0
) (
  input  logic              ck_i,
  input  logic              rstn_i,
  spr16x4_ctrl_if.slave     bus,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_EXEC = 3'd2,
    ST_CLR  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam state_t     C_RST_STATE = CLR_ON_RESET ? ST_INIT : ST_IDLE;
  localparam logic [1:0] C_OP_READ   = 2'b00;
  localparam logic [1:0] C_OP_WRITE  = 2'b01;
  localparam logic [1:0] C_OP_ADD    = 2'b10;
  localparam logic [1:0] C_OP_CLEAR  = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic [3:0] rsp_addr_q, rsp_addr_d;

  logic [4:0] w_sum;
  logic [3:0] w_add;
  logic [3:0] w_mem_ad;
  logic [3:0] w_mem_di;
  logic       w_wre;

  // --------------------------------------------------------------------------
  // RAM datapath. Purely a function of the registered state; the only
  // combinational input is mem_do feeding the adder during an add.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum = {1'b0, bus.mem_do} + {1'b0, data_q};
    w_add = (SAT && w_sum[4]) ? 4'hF : w_sum[3:0];
  end

  always_comb begin
    w_mem_ad = addr_q;
    w_mem_di = 4'h0;
    w_wre    = 1'b0;
    case (state_q)
      ST_INIT, ST_CLR: begin
        w_mem_ad = cnt_q;
        w_wre    = 1'b1;
      end
      ST_EXEC: begin
        case (op_q)
          C_OP_WRITE: begin
            w_wre    = 1'b1;
            w_mem_di = data_q;
          end
          C_OP_ADD: begin
            w_wre    = 1'b1;
            w_mem_di = w_add;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.mem_ad  = w_mem_ad;
  assign bus.mem_di  = w_mem_di;
  // INIT is the reset state when clearing on reset, so the write enable is
  // qualified with the reset pin: no write may reach the RAM while reset is
  // held, and it must drop the instant reset asserts mid-sweep.
  assign bus.mem_wre = w_wre & rstn_i;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          addr_d  = bus.cmd_addr;
          data_d  = bus.cmd_data;
          cnt_d   = 4'h0;
          state_d = (bus.cmd_op == C_OP_CLEAR) ? ST_CLR : ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Read returns the stored word; write/add return what was written.
        rsp_data_d  = (op_q == C_OP_READ) ? bus.mem_do : w_mem_di;
        rsp_addr_d  = addr_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_CLR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          rsp_data_d  = 4'h0;
          rsp_addr_d  = 4'h0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = C_RST_STATE;
      end
    endcase
  end

  always_ff @(posedge ck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= C_RST_STATE;
      cnt_q       <= 4'h0;
      op_q        <= 2'b00;
      addr_q      <= 4'h0;
      data_q      <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_addr_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spr16x4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spr16x4_ctrl
// Description : Self-checking bench for spr16x4_ctrl. Instance u_dut
//               (clear-on-reset, wrapping add) is checked every cycle against
//               a transaction-level model; instance u_dut_sat (no clear on
//               reset, saturating add) gets directed checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spr16x4_ctrl;

  logic ck = 1'b0;
  logic rstn0 = 1'b1;
  logic rstn1 = 1'b1;
  always #5 ck = ~ck;

  spr16x4_ctrl_if bus0();
  spr16x4_ctrl_if bus1();
  logic busy0, busy1;

  spr16x4_ctrl #(.CLR_ON_RESET(1'b1), .SAT(1'b0)) u_dut (
    .ck_i(ck), .rstn_i(rstn0), .bus(bus0.slave), .busy_o(busy0));
  spr16x4_ctrl #(.CLR_ON_RESET(1'b0), .SAT(1'b1)) u_dut_sat (
    .ck_i(ck), .rstn_i(rstn1), .bus(bus1.slave), .busy_o(busy1));

  // Behavioural LUT-RAMs: synchronous write, asynchronous read.
  logic [3:0] ram0 [16];
  logic [3:0] ram1 [16];
  always @(posedge ck) if (bus0.mem_wre) ram0[bus0.mem_ad] <= bus0.mem_di;
  always @(posedge ck) if (bus1.mem_wre) ram1[bus1.mem_ad] <= bus1.mem_di;
  assign bus0.mem_do = ram0[bus0.mem_ad];
  assign bus1.mem_do = ram1[bus1.mem_ad];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] add_ref(input logic [3:0] a, input logic [3:0] b,
                                         input bit sat);
    int s;
    s = int'(a) + int'(b);
    if (s > 15) return sat ? 4'hF : 4'(s - 16);
    return 4'(s);
  endfunction

  // --------------------------------------------------------------------------
  // Reference model for u_dut: expected memory image plus a schedule of
  // outstanding work (sweep cycles left, command cycles left, pending reply).
  // Evaluated on the falling edge; inputs only change just after rising edges.
  // --------------------------------------------------------------------------
  logic [3:0] ref0 [16];
  int         m_init_left = 0;
  int         m_left      = 0;
  bit         m_clr       = 1'b0;
  logic [1:0] m_op;
  logic [3:0] m_addr, m_data;
  bit         m_pend      = 1'b0;
  logic [3:0] m_rdata, m_raddr;

  always @(negedge ck) begin
    bit         erdy;
    bit         ew;
    logic [3:0] ead, edi;
    if (!rstn0) begin
      check("rst_cmd_ready", bus0.cmd_ready, 0);
      check("rst_busy",      busy0,          1);
      check("rst_rsp_valid", bus0.rsp_valid, 0);
      check("rst_rsp_data",  bus0.rsp_data,  0);
      check("rst_mem_wre",   bus0.mem_wre,   0);
      check("rst_mem_ad",    bus0.mem_ad,    0);
      m_init_left = 16;
      m_left      = 0;
      m_pend      = 1'b0;
    end else begin
      erdy = (m_init_left == 0) && (m_left == 0) && !m_pend;
      ew = 1'b0; ead = 4'h0; edi = 4'h0;
      if (m_init_left > 0) begin
        ew = 1'b1; ead = 4'(16 - m_init_left);
      end else if (m_left > 0 && m_clr) begin
        ew = 1'b1; ead = 4'(16 - m_left);
      end else if (m_left > 0) begin
        ead = m_addr;
        if (m_op == 2'd1) begin ew = 1'b1; edi = m_data; end
        if (m_op == 2'd2) begin ew = 1'b1; edi = add_ref(ref0[m_addr], m_data, 1'b0); end
      end
      check("cmd_ready", bus0.cmd_ready, erdy);
      check("busy",      busy0,          !erdy);
      check("rsp_valid", bus0.rsp_valid, m_pend);
      if (m_pend) begin
        check("rsp_data", bus0.rsp_data, m_rdata);
        check("rsp_addr", bus0.rsp_addr, m_raddr);
      end
      check("mem_wre", bus0.mem_wre, ew);
      if (ew) begin
        check("mem_ad", bus0.mem_ad, ead);
        check("mem_di", bus0.mem_di, edi);
      end
      // advance across the coming rising edge
      if (m_init_left > 0) begin
        ref0[ead] = 4'h0;
        m_init_left--;
      end else if (m_left > 0 && m_clr) begin
        ref0[ead] = 4'h0;
        m_left--;
        if (m_left == 0) begin m_pend = 1'b1; m_rdata = 4'h0; m_raddr = 4'h0; end
      end else if (m_left > 0) begin
        m_rdata = (m_op == 2'd0) ? ref0[m_addr] : edi;
        m_raddr = m_addr;
        if (ew) ref0[m_addr] = edi;
        m_left  = 0;
        m_pend  = 1'b1;
      end else if (m_pend) begin
        if (bus0.rsp_ready) m_pend = 1'b0;
      end else if (bus0.cmd_valid) begin
        m_op = bus0.cmd_op; m_addr = bus0.cmd_addr; m_data = bus0.cmd_data;
        m_clr  = (bus0.cmd_op == 2'd3);
        m_left = m_clr ? 16 : 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // u_dut stimulus helpers
  // --------------------------------------------------------------------------
  task automatic issue0(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
    bit ok = 1'b0;
    bus0.cmd_op = op; bus0.cmd_addr = a; bus0.cmd_data = d; bus0.cmd_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge ck);
      if (bus0.cmd_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", ok, 1);
    @(posedge ck); #1;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_op = 2'($urandom); bus0.cmd_addr = 4'($urandom); bus0.cmd_data = 4'($urandom);
  endtask

  task automatic wait_rsp0(input int hold, output logic [3:0] d, output logic [3:0] a,
                           output int lat);
    bit ok = 1'b0;
    lat = 0; d = 4'h0; a = 4'h0;
    for (int t = 0; t < 40; t++) begin
      @(negedge ck);
      lat++;
      if (bus0.rsp_valid) begin ok = 1'b1; break; end
    end
    check("rsp_timeout", ok, 1);
    d = bus0.rsp_data; a = bus0.rsp_addr;
    for (int h = 0; h < hold; h++) begin
      @(posedge ck); #1;
      @(negedge ck);
      check("hold_valid", bus0.rsp_valid, 1);
      check("hold_data",  bus0.rsp_data,  d);
      check("hold_ready", bus0.cmd_ready, 0);
    end
    @(posedge ck); #1 bus0.rsp_ready = 1'b1;
    @(posedge ck); #1 bus0.rsp_ready = 1'b0;
  endtask

  task automatic cmd1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d,
                      input bit nowait, output logic [3:0] rd);
    bit ok = 1'b0;
    rd = 4'h0;
    bus1.cmd_op = op; bus1.cmd_addr = a; bus1.cmd_data = d; bus1.cmd_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge ck);
      if (bus1.cmd_ready) begin ok = 1'b1; break; end
    end
    check("b_accept_timeout", ok, 1);
    @(posedge ck); #1 bus1.cmd_valid = 1'b0;
    if (!nowait) begin
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge ck);
        if (bus1.rsp_valid) begin ok = 1'b1; rd = bus1.rsp_data; break; end
      end
      check("b_rsp_timeout", ok, 1);
      @(posedge ck); #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [3:0] d, a, snap [16];
    int         lat, op;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'b00; bus0.cmd_addr = 4'h0; bus0.cmd_data = 4'h0;
    bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 2'b00; bus1.cmd_addr = 4'h0; bus1.cmd_data = 4'h0;
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin ram0[i] = 4'hA; ref0[i] = 4'hA; ram1[i] = 4'h0; end
    #1 rstn0 = 1'b0; rstn1 = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    check("b_rst_ready", bus1.cmd_ready, 1);
    check("b_rst_busy",  busy1, 0);
    rstn1 = 1'b1;

    // ---- saturating instance, directed ----
    cmd1(2'd1, 4'd3, 4'hE, 1'b0, d);  check("b_wr3", d, 4'hE);
    cmd1(2'd2, 4'd3, 4'h3, 1'b0, d);  check("b_sat_add", d, 4'hF);
    cmd1(2'd0, 4'd3, 4'h0, 1'b0, d);  check("b_sat_read", d, 4'hF);
    cmd1(2'd1, 4'd2, 4'h5, 1'b0, d);
    cmd1(2'd2, 4'd2, 4'h3, 1'b0, d);  check("b_add_nosat", d, 4'h8);
    for (int i = 0; i < 16; i++) cmd1(2'd1, 4'(i), 4'hC, 1'b0, d);
    cmd1(2'd3, 4'd9, 4'h9, 1'b1, d);
    repeat (7) @(posedge ck);
    #2 rstn1 = 1'b0;
    #1 check("b_rst_wre_drop", bus1.mem_wre, 0);
    @(negedge ck);
    for (int i = 0; i < 16; i++) check("b_partial_clr", ram1[i], (i < 7) ? 0 : 12);
    @(posedge ck); #1 rstn1 = 1'b1;
    @(negedge ck);
    check("b_no_rsp", bus1.rsp_valid, 0);
    check("b_idle_ready", bus1.cmd_ready, 1);
    cmd1(2'd0, 4'd7, 4'h0, 1'b0, d);  check("b_read7", d, 4'hC);
    cmd1(2'd0, 4'd6, 4'h0, 1'b0, d);  check("b_read6", d, 4'h0);

    // ---- clear-on-reset instance ----
    @(posedge ck); #1 rstn0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue0(2'd0, 4'(i), 4'h0);
      wait_rsp0(0, d, a, lat);
      check("init_read", d, 0);
    end
    issue0(2'd1, 4'd5, 4'h9); wait_rsp0(0, d, a, lat);
    check("wr5_data", d, 9); check("wr5_addr", a, 5); check("wr5_lat", lat, 2);
    issue0(2'd0, 4'd5, 4'h0); wait_rsp0(0, d, a, lat);
    check("rd5_data", d, 9); check("rd5_addr", a, 5); check("rd5_lat", lat, 2);
    issue0(2'd1, 4'd3, 4'hE); wait_rsp0(0, d, a, lat);
    issue0(2'd2, 4'd3, 4'h3); wait_rsp0(0, d, a, lat);
    check("wrap_add", d, 1);
    check("wrap_stored", ram0[3], 1);

    // held response with a command queued behind it
    issue0(2'd0, 4'd5, 4'h0);
    bus0.cmd_op = 2'd1; bus0.cmd_addr = 4'd6; bus0.cmd_data = 4'h7; bus0.cmd_valid = 1'b1;
    wait_rsp0(10, d, a, lat);
    check("held_data", d, 9);
    issue0(2'd1, 4'd6, 4'h7); wait_rsp0(0, d, a, lat);
    check("queued_wr", d, 7);
    check("queued_stored", ram0[6], 7);

    issue0(2'd3, 4'd4, 4'h4); wait_rsp0(0, d, a, lat);
    check("clr_data", d, 0); check("clr_addr", a, 0); check("clr_lat", lat, 17);
    for (int i = 0; i < 16; i++) check("clr_word", ram0[i], 0);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      op = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      issue0(2'(op), 4'($urandom), 4'($urandom));
      wait_rsp0(int'($urandom_range(0, 3)), d, a, lat);
      check("rand_lat", lat, (op == 3) ? 17 : 2);
      repeat ($urandom_range(0, 2)) @(posedge ck);
      #1;
    end

    // reset during the 8th clear cycle, then the power-on sweep again
    issue0(2'd1, 4'd9, 4'h7); wait_rsp0(0, d, a, lat);
    for (int i = 0; i < 16; i++) snap[i] = ram0[i];
    issue0(2'd3, 4'd0, 4'h0);
    repeat (7) @(posedge ck);
    #2 rstn0 = 1'b0;
    #1 check("rst_wre_drop", bus0.mem_wre, 0);
    @(negedge ck);
    for (int i = 0; i < 16; i++) check("partial_clr", ram0[i], (i < 7) ? 0 : int'(snap[i]));
    check("kept9", ram0[9], 7);
    @(posedge ck); #1 rstn0 = 1'b1;
    issue0(2'd0, 4'd9, 4'h0); wait_rsp0(0, d, a, lat);
    check("post_init_read", d, 0);
    for (int i = 0; i < 16; i++) check("final_image", ram0[i], ref0[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
